// File: rtl/intf_if_pkg.sv
// intf_if_pkg: shared width helpers and defaults for the intf_if a/b channel
package intf_if_pkg;
  localparam int DEFAULT_W = 16;
  function automatic int clog2(input logic [127:0] v);
    int r;
    r = 0;
    while ((128'd1 << r) < v) r++;
    return r;
  endfunction
  function automatic int bw_of(input int w);
    return clog2(128'(w));
  endfunction
endpackage

// File: rtl/intf_if_popcount.sv
// intf_if_popcount: combinational count of set bits in a W-bit word
module intf_if_popcount
  import intf_if_pkg::*;
#(
  parameter int W = DEFAULT_W,
  localparam int BW = bw_of(W)
) (
  input  logic [W-1:0] i_a,
  output logic [BW:0]  o_ones
);
  logic [BW:0] w_cnt;
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < W; i++) w_cnt = w_cnt + (BW+1)'(i_a[i]);
  end
  assign o_ones = w_cnt;
endmodule

// File: rtl/intf_if_bus.sv
// intf_if_bus: registered monitor view of the generator a/b channel,
// with selected-bit and population-count decodes of the captured word
module intf_if_bus
  import intf_if_pkg::*;
#(
  parameter int W = DEFAULT_W,
  localparam int BW = bw_of(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gen_valid,
  input  logic [W-1:0]  gen_a,
  input  logic [BW-1:0] gen_b,
  output logic          mon_valid,
  output logic [W-1:0]  mon_a,
  output logic [BW-1:0] mon_b,
  output logic          mon_bit,
  output logic [BW:0]   mon_ones
);
  if (W < 2) begin : g_bad_w
    $fatal(1, "intf_if_bus: W must be at least 2");
  end
  logic          r_valid;
  logic [W-1:0]  r_a;
  logic [BW-1:0] r_b;
  logic [W-1:0]  w_sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_valid <= gen_valid;
      if (gen_valid) begin
        r_a <= gen_a;
        r_b <= gen_b;
      end
    end
  end
  // index beyond W only exists when W is not a power of two
  assign w_sh = r_a >> r_b;
  always_comb mon_bit = (32'(r_b) < W) ? w_sh[0] : 1'b0;
  intf_if_popcount #(.W(W)) u_pop (.i_a(r_a), .o_ones(mon_ones));
  assign mon_valid = r_valid;
  assign mon_a     = r_a;
  assign mon_b     = r_b;
endmodule

// File: tb/tb_intf_if_bus.sv
// tb_intf_if_bus: directed scoreboard bench for intf_if_bus at W=16 and W=10
module tb_intf_if_bus;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, gen_valid = 1'b0;
  logic [15:0] gen_a = '0;
  logic [3:0]  gen_b = '0;
  logic        mon_valid, mon_bit;
  logic [15:0] mon_a;
  logic [3:0]  mon_b;
  logic [4:0]  mon_ones;
  logic        rst10 = 1'b1, gv10 = 1'b0;
  logic [9:0]  ga10 = '0;
  logic [3:0]  gb10 = '0;
  logic        mv10, mbit10;
  logic [9:0]  ma10;
  logic [3:0]  mb10;
  logic [4:0]  mones10;
  intf_if_bus #(.W(16)) u_dut (
    .clk(clk), .rst(rst), .gen_valid(gen_valid), .gen_a(gen_a), .gen_b(gen_b),
    .mon_valid(mon_valid), .mon_a(mon_a), .mon_b(mon_b), .mon_bit(mon_bit), .mon_ones(mon_ones)
  );
  intf_if_bus #(.W(10)) u_dut10 (
    .clk(clk), .rst(rst10), .gen_valid(gv10), .gen_a(ga10), .gen_b(gb10),
    .mon_valid(mv10), .mon_a(ma10), .mon_b(mb10), .mon_bit(mbit10), .mon_ones(mones10)
  );
  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic [3:0]  b;
    logic        bt;
    logic [4:0]  ones;
  } exp_t;
  exp_t q[$];
  logic [15:0] m_a = '0;
  logic [3:0]  m_b = '0;
  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic r, input logic v, input logic [15:0] a, input logic [3:0] b);
    exp_t e;
    if (r) begin
      m_a = '0;
      m_b = '0;
    end else if (v) begin
      m_a = a;
      m_b = b;
    end
    e.v = !r && v;
    e.a = m_a;
    e.b = m_b;
    e.bt = m_a[m_b];
    e.ones = 5'($countones(m_a));
    q.push_back(e);
    rst = r; gen_valid = v; gen_a = a; gen_b = b;
    @(posedge clk); #1;
    e = q.pop_front();
    check("mon_valid", 32'(mon_valid), 32'(e.v));
    check("mon_a", 32'(mon_a), 32'(e.a));
    check("mon_b", 32'(mon_b), 32'(e.b));
    check("mon_bit", 32'(mon_bit), 32'(e.bt));
    check("mon_ones", 32'(mon_ones), 32'(e.ones));
  endtask
  task automatic beat10(input logic r, input logic v, input logic [9:0] a, input logic [3:0] b,
                        input logic [9:0] ea, input logic ebit, input logic [4:0] eones);
    rst10 = r; gv10 = v; ga10 = a; gb10 = b;
    @(posedge clk); #1;
    check("w10_mon_a", 32'(ma10), 32'(ea));
    check("w10_mon_bit", 32'(mbit10), 32'(ebit));
    check("w10_mon_ones", 32'(mones10), 32'(eones));
  endtask
  initial begin
    beat(1'b1, 1'b1, 16'hFFFF, 4'hF);
    beat(1'b1, 1'b1, 16'hFFFF, 4'hF);
    beat(1'b0, 1'b1, 16'hA5F0, 4'd4);
    check("capture_bit", 32'(mon_bit), 32'd1);
    check("capture_ones", 32'(mon_ones), 32'd8);
    beat(1'b0, 1'b0, 16'h0000, 4'd0);
    beat(1'b0, 1'b1, 16'h0001, 4'd0);
    beat(1'b0, 1'b1, 16'h0002, 4'd1);
    beat(1'b0, 1'b1, 16'h0003, 4'd2);
    beat(1'b0, 1'b0, 16'hBEEF, 4'd7);
    beat(1'b0, 1'b1, 16'hFFFF, 4'd15);
    check("full_ones", 32'(mon_ones), 32'd16);
    beat(1'b1, 1'b1, 16'h1234, 4'd3);
    beat(1'b0, 1'b1, 16'h00FF, 4'd0);
    check("resume_a", 32'(mon_a), 32'h00FF);
    for (int i = 0; i < 40; i++)
      beat(($urandom_range(0, 9) == 0), 1'($urandom), 16'($urandom), 4'($urandom));
    beat10(1'b1, 1'b1, 10'h3FF, 4'd3, 10'h000, 1'b0, 5'd0);
    beat10(1'b0, 1'b1, 10'h3FF, 4'd12, 10'h3FF, 1'b0, 5'd10);
    beat10(1'b0, 1'b1, 10'h200, 4'd9, 10'h200, 1'b1, 5'd1);
    beat10(1'b0, 1'b1, 10'h155, 4'd10, 10'h155, 1'b0, 5'd5);
    beat10(1'b0, 1'b0, 10'h000, 4'd0, 10'h155, 1'b0, 5'd5);
    check("w10_idle_valid", 32'(mv10), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
